// File: rtl/dac_sweep_pkg.sv
// dac_sweep_pkg: shared widths, limits and FSM state type
// for the DAC staircase sweep controller.
package dac_sweep_pkg;

  localparam int DAC_W = 10;
  localparam logic [DAC_W-1:0] DAC_MAX = 10'd1023;
  localparam int DIV_W = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/dac_dwell_cnt.sv
// dac_dwell_cnt: dwell timer; counts while enabled, tc when cnt==div.
// Ports: clk, rst, clr, en, div in; tc out.
module dac_dwell_cnt
  import dac_sweep_pkg::*;
#(
  parameter int DIVW = DIV_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic [DIVW-1:0] div,
  output logic            tc
);

  logic [DIVW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == div);

endmodule

// File: rtl/dac_sweep_ctrl.sv
// dac_sweep_ctrl: staircase sweep sequencer driving the DAC code bus,
// with host direct write when idle. All outputs registered.
// Ports: clk, rst, start, abort, start_code, stop_code, step, div,
// repeat_en, host_we, host_code in; dac_code, busy, step_strobe,
// done, host_rej out.
module dac_sweep_ctrl
  import dac_sweep_pkg::*;
#(
  parameter int DW   = DAC_W,
  parameter int DIVW = DIV_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [DW-1:0]   start_code,
  input  logic [DW-1:0]   stop_code,
  input  logic [DW-1:0]   step,
  input  logic [DIVW-1:0] div,
  input  logic            repeat_en,
  input  logic            host_we,
  input  logic [DW-1:0]   host_code,
  output logic [DW-1:0]   dac_code,
  output logic            busy,
  output logic            step_strobe,
  output logic            done,
  output logic            host_rej
);

  state_t          state;
  logic [DW-1:0]   start_q;
  logic [DW-1:0]   stop_q;
  logic [DW-1:0]   step_q;
  logic [DIVW-1:0] div_q;
  logic            rep_q;
  logic            up_q;

  logic            go;
  logic            tc;
  logic            at_stop;
  logic [DW:0]     sum;
  logic [DW:0]     diff;
  logic [DW-1:0]   nxt;

  assign go      = (state == IDLE) && start && !abort;
  assign at_stop = (dac_code == stop_q);

  // One extra bit catches both overflow past the top code
  // and underflow below zero, so either clamps to stop.
  assign sum  = {1'b0, dac_code} + {1'b0, step_q};
  assign diff = {1'b0, dac_code} - {1'b0, step_q};

  always_comb begin
    nxt = stop_q;
    if (up_q) begin
      if (sum < {1'b0, stop_q})
        nxt = sum[DW-1:0];
    end else begin
      if (!diff[DW] && (diff[DW-1:0] > stop_q))
        nxt = diff[DW-1:0];
    end
  end

  dac_dwell_cnt #(
    .DIVW (DIVW)
  ) u_dwell (
    .clk (clk),
    .rst (rst),
    .clr ((state != RUN) || tc || abort),
    .en  (state == RUN),
    .div (div_q),
    .tc  (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dac_code    <= '0;
      busy        <= 1'b0;
      step_strobe <= 1'b0;
      done        <= 1'b0;
      host_rej    <= 1'b0;
      start_q     <= '0;
      stop_q      <= '0;
      step_q      <= '0;
      div_q       <= '0;
      rep_q       <= 1'b0;
      up_q        <= 1'b0;
    end else begin
      step_strobe <= 1'b0;
      done        <= 1'b0;
      host_rej    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            start_q     <= start_code;
            stop_q      <= stop_code;
            step_q      <= (step == '0) ? DW'(1) : step;
            div_q       <= div;
            rep_q       <= repeat_en;
            up_q        <= (stop_code >= start_code);
            dac_code    <= start_code;
            busy        <= 1'b1;
            step_strobe <= 1'b1;
            host_rej    <= host_we;
            state       <= RUN;
          end else if (host_we) begin
            dac_code <= host_code;
          end
        end
        RUN: begin
          host_rej <= host_we;
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (tc) begin
            if (at_stop) begin
              if (rep_q) begin
                dac_code    <= start_q;
                step_strobe <= 1'b1;
              end else begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= IDLE;
              end
            end else begin
              dac_code    <= nxt;
              step_strobe <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_sweep_ctrl.sv
// tb_dac_sweep_ctrl: randomized and directed checks of dac_sweep_ctrl
// against a code-list model of the sweep.
module tb_dac_sweep_ctrl;

  localparam int DW   = 10;
  localparam int DIVW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [DW-1:0]   start_code = '0;
  logic [DW-1:0]   stop_code = '0;
  logic [DW-1:0]   step = '0;
  logic [DIVW-1:0] div = '0;
  logic            repeat_en = 1'b0;
  logic            host_we = 1'b0;
  logic [DW-1:0]   host_code = '0;
  logic [DW-1:0]   dac_code;
  logic            busy;
  logic            step_strobe;
  logic            done;
  logic            host_rej;

  int vectors = 0;
  int miscompares = 0;
  int codes[$];

  dac_sweep_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .start_code  (start_code),
    .stop_code   (stop_code),
    .step        (step),
    .div         (div),
    .repeat_en   (repeat_en),
    .host_we     (host_we),
    .host_code   (host_code),
    .dac_code    (dac_code),
    .busy        (busy),
    .step_strobe (step_strobe),
    .done        (done),
    .host_rej    (host_rej)
  );

  always #5 clk = ~clk;

  // Expected list of distinct codes visited by one pass.
  task automatic fill_codes(input int s, input int e, input int st);
    int c;
    codes.delete();
    if (st == 0) st = 1;
    c = s;
    codes.push_back(c);
    while (c != e) begin
      if (e > s) c = (c + st > e) ? e : c + st;
      else       c = (c - st < e) ? e : c - st;
      codes.push_back(c);
    end
  endtask

  task automatic idle_inputs();
    start   = 1'b0;
    abort   = 1'b0;
    host_we = 1'b0;
  endtask

  // Launch a sweep and check every cycle up to done (or the wrap).
  task automatic run_sweep(input int s, input int e, input int st,
                           input int d, input bit rep, input bit noisy);
    int period;
    int total;
    bit prev_we;
    logic [DW-1:0] ec;
    logic [DW+3:0] got;
    logic [DW+3:0] exp;
    fill_codes(s, e, st);
    period = d + 1;
    total  = codes.size() * period;
    @(negedge clk);
    start      = 1'b1;
    abort      = 1'b0;
    host_we    = 1'b0;
    start_code = DW'(s);
    stop_code  = DW'(e);
    step       = DW'(st);
    div        = DIVW'(d);
    repeat_en  = rep;
    prev_we    = 1'b0;
    for (int k = 1; k <= total + 1; k++) begin
      @(negedge clk);
      if (k <= total) begin
        ec  = DW'(codes[(k - 1) / period]);
        exp = {ec, 1'b1, ((k - 1) % period) == 0, 1'b0, prev_we};
      end else if (rep) begin
        exp = {DW'(s), 1'b1, 1'b1, 1'b0, prev_we};
      end else begin
        exp = {DW'(e), 1'b0, 1'b0, 1'b1, prev_we};
      end
      got = {dac_code, busy, step_strobe, done, host_rej};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL sweep %0d->%0d st=%0d div=%0d k=%0d {code,busy,strb,done,rej} got=%h want=%h",
                 s, e, st, d, k, got, exp);
      end
      if (noisy && k <= total) begin
        start      = 1'($urandom);
        host_we    = 1'($urandom);
        host_code  = DW'($urandom);
        start_code = DW'($urandom);
        stop_code  = DW'($urandom);
        step       = DW'($urandom);
        div        = DIVW'($urandom_range(0, 5));
        repeat_en  = 1'($urandom);
      end else begin
        idle_inputs();
      end
      prev_we = host_we;
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    vectors++;
    if ({dac_code, busy, step_strobe, done, host_rej} !== '0) begin
      miscompares++;
      $display("FAIL reset got code=%0d busy=%b strb=%b done=%b rej=%b want all 0",
               dac_code, busy, step_strobe, done, host_rej);
    end
    rst = 1'b0;
  endtask

  task automatic test_up();
    run_sweep(0, 9, 3, 1, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    run_sweep(1000, 1023, 10, 0, 1'b0, 1'b0);
    run_sweep(1020, 1023, 1023, 1, 1'b0, 1'b0);
  endtask

  task automatic test_down();
    run_sweep(20, 5, 7, 2, 1'b0, 1'b0);
    run_sweep(20, 5, 0, 2, 1'b0, 1'b0);
    run_sweep(3, 0, 500, 0, 1'b0, 1'b0);
  endtask

  task automatic test_single();
    run_sweep(77, 77, 4, 3, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    @(negedge clk);
    start = 1'b1; start_code = 0; stop_code = 9;
    step = 3; div = 1; repeat_en = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (dac_code !== 10'd3 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_pre got code=%0d busy=%b want 3 1", dac_code, busy);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    vectors++;
    if ({dac_code, busy, step_strobe, done} !== {10'd3, 3'b000}) begin
      miscompares++;
      $display("FAIL abort got code=%0d busy=%b strb=%b done=%b want 3 0 0 0",
               dac_code, busy, step_strobe, done);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if ({dac_code, busy, done} !== {10'd3, 2'b00}) begin
        miscompares++;
        $display("FAIL abort_hold got code=%0d busy=%b done=%b want 3 0 0",
                 dac_code, busy, done);
      end
    end
    run_sweep(0, 9, 3, 1, 1'b0, 1'b0);
  endtask

  task automatic test_host();
    @(negedge clk);
    host_we = 1'b1; host_code = 10'd512;
    @(negedge clk);
    idle_inputs();
    vectors++;
    if ({dac_code, busy, step_strobe, host_rej} !== {10'd512, 3'b000}) begin
      miscompares++;
      $display("FAIL host_idle got code=%0d busy=%b strb=%b rej=%b want 512 0 0 0",
               dac_code, busy, step_strobe, host_rej);
    end
    start = 1'b1; abort = 1'b1; host_we = 1'b1; host_code = 10'd77;
    @(negedge clk);
    idle_inputs();
    vectors++;
    if ({dac_code, busy, host_rej} !== {10'd77, 2'b00}) begin
      miscompares++;
      $display("FAIL start_abort got code=%0d busy=%b rej=%b want 77 0 0",
               dac_code, busy, host_rej);
    end
    start = 1'b1; start_code = 10'd100; stop_code = 10'd110;
    step = 10'd5; div = 16'd3; repeat_en = 1'b0;
    host_we = 1'b1; host_code = 10'd300;
    @(negedge clk);
    idle_inputs();
    vectors++;
    if ({dac_code, busy, step_strobe, host_rej} !== {10'd100, 3'b111}) begin
      miscompares++;
      $display("FAIL start_host got code=%0d busy=%b strb=%b rej=%b want 100 1 1 1",
               dac_code, busy, step_strobe, host_rej);
    end
    host_we = 1'b1; host_code = 10'd600;
    @(negedge clk);
    idle_inputs();
    vectors++;
    if ({dac_code, busy, host_rej} !== {10'd100, 2'b11}) begin
      miscompares++;
      $display("FAIL host_run got code=%0d busy=%b rej=%b want 100 1 1",
               dac_code, busy, host_rej);
    end
    abort = 1'b1;
    @(negedge clk);
    idle_inputs();
    vectors++;
    if ({dac_code, busy, done, host_rej} !== {10'd100, 3'b000}) begin
      miscompares++;
      $display("FAIL host_abort got code=%0d busy=%b done=%b rej=%b want 100 0 0 0",
               dac_code, busy, done, host_rej);
    end
  endtask

  task automatic test_repeat_reset();
    run_sweep(0, 9, 3, 1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    vectors++;
    if ({dac_code, busy, step_strobe} !== {10'd3, 2'b11}) begin
      miscompares++;
      $display("FAIL repeat_pass2 got code=%0d busy=%b strb=%b want 3 1 1",
               dac_code, busy, step_strobe);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat_en = 1'b0;
    vectors++;
    if ({dac_code, busy, step_strobe, done} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset got code=%0d busy=%b strb=%b done=%b want 0 0 0 0",
               dac_code, busy, step_strobe, done);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if ({dac_code, busy, step_strobe} !== '0) begin
      miscompares++;
      $display("FAIL post_reset got code=%0d busy=%b strb=%b want 0 0 0",
               dac_code, busy, step_strobe);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_sweep($urandom_range(0, 1023), $urandom_range(0, 1023),
                $urandom_range(0, 40), $urandom_range(0, 3),
                1'b0, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_up();
    test_saturation();
    test_down();
    test_single();
    test_abort();
    test_host();
    test_repeat_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
